// File: rtl/execute_stage_pkg.sv
// Shared encodings and pipeline bundle types for the RV32I execute stage.
// ALU control codes are shared with decode; B_* codes produce zero when the branch is taken.
package execute_stage_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] B_BNE     = 4'd10;
  localparam logic [3:0] B_BLT     = 4'd11;
  localparam logic [3:0] B_BGE     = 4'd12;
  localparam logic [3:0] B_BLTU    = 4'd13;
  localparam logic [3:0] B_BGEU    = 4'd14;
  localparam logic [3:0] ALU_PASSB = 4'd15;

  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic        pc_src;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        jump;
    logic        overflow;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd_addr;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// RV32I ALU: arithmetic/logic ops plus branch compares that return zero when taken.
module alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            overflow
);
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            lt_s;
  logic            lt_u;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $signed(a) >>> b[4:0];
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, lt_u};
      // Branch compares: zero means taken
      B_BNE:     result = {{(XLEN-1){1'b0}}, (a == b)};
      B_BLT:     result = {{(XLEN-1){1'b0}}, !lt_s};
      B_BGE:     result = {{(XLEN-1){1'b0}}, lt_s};
      B_BLTU:    result = {{(XLEN-1){1'b0}}, !lt_u};
      B_BGEU:    result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero_flag = (result == '0);
endmodule

// File: rtl/execute_stage_forward_unit.sv
// Operand forwarding selects (MEM over WB over register file) and load-use detection.
module forward_unit
  import execute_stage_pkg::*;
(
  input  logic       in_valid,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       mem_valid,
  input  logic       mem_reg_write,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output fwd_sel_t   rs1_sel,
  output fwd_sel_t   rs2_sel,
  output logic       load_use_stall
);
  logic [4:0] rs_addr [2];
  fwd_sel_t   sel [2];

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  // A load in EX/MEM has no data yet, so it is never a forwarding source
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sel
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = mem_valid && mem_reg_write && !mem_mem_read && (mem_rd == rs_addr[gi]);
      assign wb_hit  = wb_reg_write && (wb_rd == rs_addr[gi]);
      assign sel[gi] = (rs_addr[gi] == 5'd0) ? FWD_REG :
                       mem_hit               ? FWD_MEM :
                       wb_hit                ? FWD_WB  : FWD_REG;
    end
  endgenerate

  assign rs1_sel = sel[0];
  assign rs2_sel = sel[1];

  assign load_use_stall = in_valid && mem_valid && mem_mem_read && (mem_rd != 5'd0) &&
                          ((mem_rd == rs1_addr) || (mem_rd == rs2_addr));
endmodule

// File: rtl/execute_stage.sv
// RV32I EX stage: operand forwarding, ALU, branch/jump resolution, registered EX/MEM bundle.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter logic [31:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [3:0]      in_alu_control,
  input  logic            in_alu_src,
  input  logic            in_pc_src,
  input  logic            in_branch,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            load_use_stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic            out_overflow,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [4:0]      out_rd_addr
);
  id_ex_t    id_ex;
  ex_mem_t   ex_mem_reg;
  ex_mem_t   ex_mem_next;
  fwd_sel_t  rs1_sel;
  fwd_sel_t  rs2_sel;
  logic [31:0] mem_fwd_data;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic [31:0] jalr_sum;
  logic        taken;
  logic        adv;

  assign id_ex = '{valid: in_valid, pc: in_pc, rs1_data: in_rs1_data, rs2_data: in_rs2_data,
                   imm: in_imm, rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr,
                   rd_addr: in_rd_addr, alu_control: in_alu_control, alu_src: in_alu_src,
                   pc_src: in_pc_src, branch: in_branch, jal: in_jal, jalr: in_jalr,
                   mem_read: in_mem_read, mem_write: in_mem_write, reg_write: in_reg_write,
                   mem_to_reg: in_mem_to_reg};

  forward_unit u_forward_unit (
    .in_valid       (id_ex.valid),
    .rs1_addr       (id_ex.rs1_addr),
    .rs2_addr       (id_ex.rs2_addr),
    .mem_valid      (ex_mem_reg.valid),
    .mem_reg_write  (ex_mem_reg.reg_write),
    .mem_mem_read   (ex_mem_reg.mem_read),
    .mem_rd         (ex_mem_reg.rd_addr),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .rs1_sel        (rs1_sel),
    .rs2_sel        (rs2_sel),
    .load_use_stall (load_use_stall)
  );

  // A jump in EX/MEM writes its link address, not the ALU result
  assign mem_fwd_data = ex_mem_reg.jump ? ex_mem_reg.pc_plus4 : ex_mem_reg.alu_result;

  always_comb begin
    case (rs1_sel)
      FWD_MEM: fwd_rs1 = mem_fwd_data;
      FWD_WB:  fwd_rs1 = wb_data;
      default: fwd_rs1 = id_ex.rs1_data;
    endcase
    case (rs2_sel)
      FWD_MEM: fwd_rs2 = mem_fwd_data;
      FWD_WB:  fwd_rs2 = wb_data;
      default: fwd_rs2 = id_ex.rs2_data;
    endcase
  end

  assign alu_a = id_ex.pc_src  ? id_ex.pc  : fwd_rs1;
  assign alu_b = id_ex.alu_src ? id_ex.imm : fwd_rs2;

  alu #(.XLEN(32)) u_alu (
    .alu_control (id_ex.alu_control),
    .a           (alu_a),
    .b           (alu_b),
    .result      (alu_result),
    .zero_flag   (alu_zero),
    .overflow    (alu_overflow)
  );

  assign taken           = id_ex.branch && alu_zero;
  assign adv             = id_ex.valid && !load_use_stall && !flush;
  assign jalr_sum        = fwd_rs1 + id_ex.imm;
  assign redirect_target = id_ex.jalr ? {jalr_sum[31:1], 1'b0} : (id_ex.pc + id_ex.imm);
  assign redirect_valid  = adv && !stall && (taken || id_ex.jal || id_ex.jalr);

  always_comb begin
    ex_mem_next = ex_mem_reg;
    if (stall) begin
      ex_mem_next = ex_mem_reg;
    end else if (flush || load_use_stall) begin
      ex_mem_next.valid     = 1'b0;
      ex_mem_next.reg_write = 1'b0;
      ex_mem_next.mem_read  = 1'b0;
      ex_mem_next.mem_write = 1'b0;
    end else begin
      ex_mem_next.valid      = id_ex.valid;
      ex_mem_next.reg_write  = id_ex.valid && id_ex.reg_write;
      ex_mem_next.mem_read   = id_ex.valid && id_ex.mem_read;
      ex_mem_next.mem_write  = id_ex.valid && id_ex.mem_write;
      ex_mem_next.jump       = id_ex.valid && (id_ex.jal || id_ex.jalr);
      ex_mem_next.mem_to_reg = id_ex.valid && id_ex.mem_to_reg && !(id_ex.jal || id_ex.jalr);
      ex_mem_next.overflow   = alu_overflow;
      ex_mem_next.alu_result = alu_result;
      ex_mem_next.store_data = fwd_rs2;
      ex_mem_next.pc_plus4   = id_ex.pc + 32'd4;
      ex_mem_next.rd_addr    = id_ex.rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_reg          <= '0;
      ex_mem_reg.pc_plus4 <= RESET_PC_PLUS4;
    end else begin
      ex_mem_reg <= ex_mem_next;
    end
  end

  assign out_valid      = ex_mem_reg.valid;
  assign out_reg_write  = ex_mem_reg.reg_write;
  assign out_mem_read   = ex_mem_reg.mem_read;
  assign out_mem_write  = ex_mem_reg.mem_write;
  assign out_mem_to_reg = ex_mem_reg.mem_to_reg;
  assign out_overflow   = ex_mem_reg.overflow;
  assign out_alu_result = ex_mem_reg.alu_result;
  assign out_store_data = ex_mem_reg.store_data;
  assign out_pc_plus4   = ex_mem_reg.pc_plus4;
  assign out_rd_addr    = ex_mem_reg.rd_addr;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: driver queues hand-computed EX/MEM expectations,
// an independent negedge monitor pops and compares them one cycle later.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]  in_alu_control;
  logic        in_alu_src, in_pc_src, in_branch, in_jal, in_jalr;
  logic        in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        load_use_stall, redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_overflow;
  logic [31:0] out_alu_result, out_store_data, out_pc_plus4;
  logic [4:0]  out_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    string       name;
    int          due;
    logic        v, rw, mr, mw, m2r, ovf;
    logic [31:0] alu, sd, pc4;
    logic [4:0]  rd;
    bit          chk_alu, chk_data;
  } exp_t;
  exp_t exp_q[$];

  execute_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_control(in_alu_control), .in_alu_src(in_alu_src), .in_pc_src(in_pc_src),
    .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_use_stall(load_use_stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .out_valid(out_valid), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_overflow(out_overflow), .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_pc_plus4(out_pc_plus4), .out_rd_addr(out_rd_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the registered EX/MEM bundle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e  = exp_q.pop_front();
      ok = (out_valid === e.v) && (out_reg_write === e.rw) &&
           (out_mem_read === e.mr) && (out_mem_write === e.mw);
      if (e.chk_alu)  ok = ok && (out_alu_result === e.alu) && (out_overflow === e.ovf);
      if (e.chk_data) ok = ok && (out_store_data === e.sd) && (out_pc_plus4 === e.pc4) &&
                           (out_rd_addr === e.rd) && (out_mem_to_reg === e.m2r);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got v=%b rw=%b mr=%b mw=%b m2r=%b ovf=%b alu=%h sd=%h pc4=%h rd=%0d, exp v=%b rw=%b mr=%b mw=%b m2r=%b ovf=%b alu=%h sd=%h pc4=%h rd=%0d",
                 e.name, out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                 out_overflow, out_alu_result, out_store_data, out_pc_plus4, out_rd_addr,
                 e.v, e.rw, e.mr, e.mw, e.m2r, e.ovf, e.alu, e.sd, e.pc4, e.rd);
      end else begin
        $display("txn %-14s v=%b rw=%b mr=%b mw=%b alu=%h sd=%h pc4=%h rd=%0d ok",
                 e.name, out_valid, out_reg_write, out_mem_read, out_mem_write,
                 out_alu_result, out_store_data, out_pc_plus4, out_rd_addr);
      end
    end
  end

  task automatic nop();
    stall = 0; flush = 0; in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_alu_control = ALU_ADD;
    in_alu_src = 0; in_pc_src = 0; in_branch = 0; in_jal = 0; in_jalr = 0;
    in_mem_read = 0; in_mem_write = 0; in_reg_write = 0; in_mem_to_reg = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, exp %h", name, got, want);
    end
  endtask

  task automatic push(input string name, input logic v, rw, mr, mw, m2r, ovf,
                      input logic [31:0] alu, sd, pc4, input logic [4:0] rd,
                      input bit chk_alu, chk_data);
    exp_t e;
    e = '{name: name, due: cyc + 1, v: v, rw: rw, mr: mr, mw: mw, m2r: m2r, ovf: ovf,
          alu: alu, sd: sd, pc4: pc4, rd: rd, chk_alu: chk_alu, chk_data: chk_data};
    exp_q.push_back(e);
  endtask

  // Inputs are already set; check same-cycle outputs, then advance one clock
  task automatic step(input string name, input logic lus, input logic rv, input logic [31:0] tgt);
    #1;
    check({name, ".lus"}, {31'd0, load_use_stall}, {31'd0, lus});
    check({name, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
    if (rv) check({name, ".tgt"}, redirect_target, tgt);
    @(posedge clk); #1;
  endtask

  initial begin
    nop(); reset = 1;
    @(posedge clk); #1;
    push("reset", 0,0,0,0,0,0, 32'h0, 32'h0, 32'h4, 5'd0, 1, 1);
    step("reset", 0, 0, 0);
    reset = 0;

    // ADD x1 = 5 + 7
    nop(); in_valid = 1; in_rs1_addr = 10; in_rs1_data = 5; in_rs2_addr = 11; in_rs2_data = 7;
    in_rd_addr = 1; in_reg_write = 1; in_pc = 32'h10;
    push("add_x1", 1,1,0,0,0,0, 32'd12, 32'd7, 32'h14, 5'd1, 1, 1);
    step("add_x1", 0, 0, 0);

    // ADDI x2 = x1 + 1 via MEM forward
    nop(); in_valid = 1; in_rs1_addr = 1; in_rs1_data = 32'hBAD; in_alu_src = 1; in_imm = 1;
    in_rd_addr = 2; in_reg_write = 1; in_pc = 32'h14;
    push("fwd_mem", 1,1,0,0,0,0, 32'd13, 32'd0, 32'h18, 5'd2, 1, 1);
    step("fwd_mem", 0, 0, 0);

    // LW x3, 0x10(x2)
    nop(); in_valid = 1; in_rs1_addr = 2; in_alu_src = 1; in_imm = 32'h10; in_rd_addr = 3;
    in_reg_write = 1; in_mem_read = 1; in_mem_to_reg = 1; in_pc = 32'h18;
    push("lw_x3", 1,1,1,0,1,0, 32'h1D, 32'd0, 32'h1C, 5'd3, 1, 1);
    step("lw_x3", 0, 0, 0);

    // ADD x4 = x3 + x0: load-use bubble, then WB forward
    nop(); in_valid = 1; in_rs1_addr = 3; in_rs1_data = 32'h111; in_rd_addr = 4;
    in_reg_write = 1; in_pc = 32'h1C;
    push("load_use", 0,0,0,0,0,0, 0, 0, 0, 0, 0, 0);
    step("load_use", 1, 0, 0);
    wb_reg_write = 1; wb_rd = 3; wb_data = 32'hDEAD;
    push("fwd_wb", 1,1,0,0,0,0, 32'hDEAD, 32'd0, 32'h20, 5'd4, 1, 1);
    step("fwd_wb", 0, 0, 0);

    // BNE 3 vs 4 taken, BNE 4 vs 4 not taken
    nop(); in_valid = 1; in_rs1_addr = 5; in_rs1_data = 3; in_rs2_addr = 6; in_rs2_data = 4;
    in_alu_control = B_BNE; in_branch = 1; in_pc = 32'h100; in_imm = 32'h20;
    push("bne_taken", 1,0,0,0,0,0, 0, 32'd4, 32'h104, 5'd0, 0, 1);
    step("bne_taken", 0, 1, 32'h120);
    in_rs1_data = 4;
    push("bne_nt", 1,0,0,0,0,0, 0, 32'd4, 32'h104, 5'd0, 0, 1);
    step("bne_nt", 0, 0, 0);

    // JALR x5, 4(x7); mem_to_reg must be suppressed for jumps
    nop(); in_valid = 1; in_rs1_addr = 7; in_rs1_data = 32'h203; in_imm = 4; in_alu_src = 1;
    in_jalr = 1; in_reg_write = 1; in_mem_to_reg = 1; in_rd_addr = 5; in_pc = 32'h40;
    push("jalr", 1,1,0,0,0,0, 0, 32'd0, 32'h44, 5'd5, 0, 1);
    step("jalr", 0, 1, 32'h206);

    // ADDI x6 = x5 + 1 takes the link address from EX/MEM
    nop(); in_valid = 1; in_rs1_addr = 5; in_rs1_data = 32'hBAD0; in_alu_src = 1; in_imm = 1;
    in_rd_addr = 6; in_reg_write = 1; in_pc = 32'h48;
    push("fwd_link", 1,1,0,0,0,0, 32'h45, 32'd0, 32'h4C, 5'd6, 1, 1);
    step("fwd_link", 0, 0, 0);

    // BEQ 9==9 held by stall for 3 cycles, then released
    nop(); in_valid = 1; in_rs1_addr = 8; in_rs1_data = 9; in_rs2_addr = 9; in_rs2_data = 9;
    in_alu_control = ALU_SUB; in_branch = 1; in_pc = 32'h200; in_imm = 32'h40; stall = 1;
    for (int i = 0; i < 3; i++) begin
      push("stall_hold", 1,1,0,0,0,0, 32'h45, 32'd0, 32'h4C, 5'd6, 1, 1);
      step("stall_hold", 0, 0, 0);
    end
    stall = 0;
    push("beq_taken", 1,0,0,0,0,0, 32'd0, 32'd9, 32'h204, 5'd0, 1, 1);
    step("beq_taken", 0, 1, 32'h240);

    // SW x9, 8(x8); then flush+stall holds; then flush alone kills
    nop(); in_valid = 1; in_rs1_addr = 8; in_rs1_data = 32'h300; in_rs2_addr = 9;
    in_rs2_data = 32'h55; in_imm = 8; in_alu_src = 1; in_mem_write = 1; in_pc = 32'h60;
    push("sw", 1,0,0,1,0,0, 32'h308, 32'h55, 32'h64, 5'd0, 1, 1);
    step("sw", 0, 0, 0);
    stall = 1; flush = 1;
    push("flush_stall", 1,0,0,1,0,0, 32'h308, 32'h55, 32'h64, 5'd0, 1, 1);
    step("flush_stall", 0, 0, 0);
    stall = 0;
    push("flush", 0,0,0,0,0,0, 0, 0, 0, 0, 0, 0);
    step("flush", 0, 0, 0);

    // Reset with a valid SW presented
    flush = 0; reset = 1;
    push("reset_mid", 0,0,0,0,0,0, 32'h0, 32'h0, 32'h4, 5'd0, 1, 1);
    step("reset_mid", 0, 0, 0);
    reset = 0;

    // ADDI x0,x0,9 then ADD x7=x0+x0: x0 never forwarded (MEM nor WB)
    nop(); in_valid = 1; in_alu_src = 1; in_imm = 9; in_reg_write = 1; in_pc = 32'h70;
    push("addi_x0", 1,1,0,0,0,0, 32'd9, 32'd0, 32'h74, 5'd0, 1, 1);
    step("addi_x0", 0, 0, 0);
    nop(); in_valid = 1; in_rd_addr = 7; in_reg_write = 1; in_pc = 32'h74;
    wb_reg_write = 1; wb_rd = 0; wb_data = 32'h77;
    push("use_x0", 1,1,0,0,0,0, 32'd0, 32'd0, 32'h78, 5'd7, 1, 1);
    step("use_x0", 0, 0, 0);

    // Signed overflow and pc+4 wrap
    nop(); in_valid = 1; in_rs1_addr = 12; in_rs1_data = 32'h7FFF_FFFF; in_rs2_addr = 13;
    in_rs2_data = 1; in_rd_addr = 8; in_reg_write = 1; in_pc = 32'hFFFF_FFFC;
    push("ovf_wrap", 1,1,0,0,0,1, 32'h8000_0000, 32'd1, 32'h0, 5'd8, 1, 1);
    step("ovf_wrap", 0, 0, 0);

    // Bubble with jump/branch fields set: no redirect, no hazard, invalid output
    nop(); in_jal = 1; in_branch = 1; in_rs1_addr = 8; in_reg_write = 1; in_mem_write = 1;
    push("bubble", 0,0,0,0,0,0, 0, 0, 0, 0, 0, 0);
    step("bubble", 0, 0, 0);
    nop();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage of the RV32I core. Consumes the ID/EX bundle from decode.
- Selects and forwards operands into the ALU, resolves branches and jumps, and detects load-use hazards.
- Produces the registered EX/MEM bundle consumed by the memory stage.
- Instantiates the existing ALU unchanged. ALU control encodings come from the common package.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_PLUS4, 32'h0000_0004, reset value of out_pc_plus4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  downstream hold; the EX/MEM register keeps its value.
- flush  in  1  kill the current EX instruction; a bubble enters EX/MEM.
- in_valid  in  1  ID/EX entry valid.
- in_pc, in_rs1_data, in_rs2_data, in_imm  in  32 each  ID/EX operands.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  register indices.
- in_alu_control  in  4  ALU_*/B_* code from the common package.
- in_alu_src  in  1  1 = right operand is in_imm.
- in_pc_src  in  1  1 = left operand is in_pc (AUIPC).
- in_branch, in_jal, in_jalr  in  1 each  control-flow class.
- in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg  in  1 each  downstream controls.
- wb_reg_write  in  1, wb_rd  in  5, wb_data  in  32  writeback forwarding source.
- load_use_stall  out  1  combinational; upstream must hold ID/EX.
- redirect_valid  out  1  combinational; taken branch or jump.
- redirect_target  out  32  combinational; redirect address.
- out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_overflow  out  1 each  EX/MEM register.
- out_alu_result, out_store_data, out_pc_plus4  out  32 each  EX/MEM register.
- out_rd_addr  out  5  EX/MEM register.

Behaviour:
- Reset (synchronous, clk edge with reset=1): out_pc_plus4 = RESET_PC_PLUS4; every other registered output is 0.
- Forwarding, per source operand:
  - Index 0 is never forwarded.
  - MEM source is the EX/MEM register itself: out_valid & out_reg_write & !out_mem_read & out_rd_addr==rsX. Its data is out_alu_result, or out_pc_plus4 when the entry was a jump.
  - Next priority is WB: wb_reg_write & wb_rd==rsX gives wb_data.
  - Otherwise the in_* register data is used.
- Operand select:
  - left = in_pc_src ? in_pc : fwd_rs1.
  - right = in_alu_src ? in_imm : fwd_rs2.
  - out_store_data = fwd_rs2.
- Load-use: load_use_stall = in_valid & out_valid & out_mem_read & out_rd_addr!=0 & (out_rd_addr==in_rs1_addr | out_rd_addr==in_rs2_addr). Comparing against rs2 when it is unused is acceptable (conservative).
- Advance: adv = in_valid & !load_use_stall & !flush.
- Branch taken = in_branch & ALU zero_flag. B_* codes return 0 when taken; BEQ uses ALU_SUB.
- Redirect target: jalr gives (fwd_rs1 + in_imm) & ~1; branch/jal give in_pc + in_imm. This uses a dedicated adder, not the ALU.
- redirect_valid = adv & !stall & (taken | in_jal | in_jalr). It is asserted only in the cycle the instruction leaves EX.
- Register update priority per clk edge: reset > stall > flush > load_use_stall > normal.
  - stall: all out_* hold, including out_valid. Flush is ignored during stall; the issuer re-asserts it.
  - flush or load_use_stall: out_valid=0; out_reg_write, out_mem_read, out_mem_write forced to 0; data fields don't-care (implement as hold).
  - normal: out_valid=in_valid.
    - out_alu_result = ALU result.
    - out_pc_plus4 = in_pc+4, wrapping mod 2^32.
    - out_overflow = ALU overflow.
    - Controls are copied with in_valid gating.
    - Jumps force out_mem_to_reg=0. WB selects pc+4 via a jump flag held internally.
- Latency: 1 cycle ID/EX → EX/MEM. Redirect and hazard signals are same-cycle combinational.
- Bubble (in_valid=0): no redirect, no hazard, out_valid=0 next cycle.

Decomposition:
- Common package additions: fwd_sel_t enum {FWD_REG, FWD_MEM, FWD_WB}; id_ex_t and ex_mem_t packed structs. ALU_*/B_* codes remain there.
- Sub-modules:
  - The existing ALU, instantiated.
  - One new combinational sub-module, forward_unit, producing both fwd_sel_t selects and load_use_stall.

Test Plan:
- Back-to-back dependency: ADD x1=5+7, then ADD x2=x1+1 → MEM forward used, out_alu_result 12 then 13, no stall.
- Load-use: LW x3 in EX/MEM, then ADD x4=x3+x0 → load_use_stall=1 for one cycle, out_valid=0 bubble, then WB forward (wb_data=0xDEAD) gives 0xDEAD.
- Branch: BNE with rs1=3, rs2=4, pc=0x100, imm=0x20 → redirect_valid=1, target 0x120. BNE with rs1=rs2=4 → redirect_valid=0.
- JALR: rs1=0x203, imm=4, pc=0x40 → target 0x206, out_pc_plus4=0x44, reg_write=1.
- Stall then flush:
  - stall=1 for 3 cycles → outputs constant, redirect_valid=0.
  - flush=1 with stall=0 → out_valid=0, out_mem_write=0.
  - flush together with stall → hold.
- Reset mid-stream with valid SW in flight → next cycle out_valid=0, out_mem_write=0, out_pc_plus4=0x4. The x0 destination is never forwarded: ADDI x0,x0,9 followed by use of x0 → operand 0.
